// File: rtl/division_block_if.sv
// division_block_if: start/done handshake and operand/result bus of the multi-cycle divider.
interface division_block_if #(parameter int WIDTH = 64);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;
    modport master (
        output start_i, signed_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/division_block.sv
// division_block: radix-2 restoring signed/unsigned divider, one quotient bit per cycle.
module division_block #(
    parameter int WIDTH = 64
) (
    input  logic clk,
    input  logic reset_i,
    division_block_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] rem, quo, dvs, quotient, remainder;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, diff;
    logic [WIDTH:0]   shifted;
    logic [CW-1:0]    cnt;
    logic             qneg, rneg, zero, done, dbz, accept, ge, divisor_zero;
    always_comb begin
        accept       = state_q == IDLE && bus.start_i;
        divisor_zero = bus.divisor_i == '0;
        dvd_mag      = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? -bus.dividend_i : bus.dividend_i;
        dvs_mag      = (bus.signed_i && bus.divisor_i[WIDTH-1]) ? -bus.divisor_i : bus.divisor_i;
        shifted      = {rem, quo[WIDTH-1]};
        ge           = shifted >= {1'b0, dvs};
        diff         = shifted[WIDTH-1:0] - dvs;
        state_d      = accept ? (divisor_zero ? FIXUP : DIVIDE)
                     : state_q == DIVIDE ? (cnt == CW'(1) ? FIXUP : DIVIDE)
                     : state_q == FIXUP ? IDLE : state_q;
    end
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state_q <= state_d;
            done    <= state_q == FIXUP;
            if (accept) begin
                qneg <= bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
                rneg <= bus.signed_i & bus.dividend_i[WIDTH-1];
                zero <= divisor_zero;
                rem  <= '0;
                // a zero divisor parks the raw dividend in quo so it can be returned as the remainder
                quo  <= divisor_zero ? bus.dividend_i : dvd_mag;
                dvs  <= dvs_mag;
                cnt  <= CW'(WIDTH);
            end else if (state_q == DIVIDE) begin
                rem <= ge ? diff : shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ge};
                cnt <= cnt - 1'b1;
            end else if (state_q == FIXUP) begin
                quotient  <= zero ? '1 : qneg ? -quo : quo;
                remainder <= zero ? quo : rneg ? -rem : rem;
                dbz       <= zero;
            end
        end
    end
    assign bus.busy_o        = state_q != IDLE;
    assign bus.done_o        = done;
    assign bus.quotient_o    = quotient;
    assign bus.remainder_o   = remainder;
    assign bus.div_by_zero_o = dbz;
endmodule

// File: tb/tb_division_block.sv
// tb_division_block: directed checks of latency, signed/unsigned results, divide-by-zero, overlap and reset abort.
module tb_division_block;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    logic saw;
    division_block_if #(.WIDTH(64)) bus ();
    division_block #(.WIDTH(64)) dut (.clk(clk), .reset_i(reset_i), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic start_op(input logic sgn, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = sgn;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(negedge clk);
        bus.start_i    = 1'b0;
        bus.dividend_i = 64'hDEAD_BEEF_0BAD_F00D;
        bus.divisor_i  = 64'h0;
    endtask
    task automatic wait_done(input int from);
        lat = from;
        while (!bus.done_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic chk_result(input string tag, input int exp_lat, input logic [63:0] q,
                              input logic [63:0] r, input logic z);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_q"}, bus.quotient_o, q);
        chk({tag, "_r"}, bus.remainder_o, r);
        chk({tag, "_dbz"}, 64'(bus.div_by_zero_o), 64'(z));
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    endtask
    initial begin
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_q", bus.quotient_o, 64'd0);
        chk("rst_r", bus.remainder_o, 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero_o), 64'd0);
        reset_i = 1'b0;
        start_op(1'b0, 64'd100, 64'd7);
        chk("u100_busy_during", 64'(bus.busy_o), 64'd1);
        wait_done(0);
        chk_result("u100_7", 65, 64'd14, 64'd2, 1'b0);
        @(negedge clk);
        chk("u100_done_pulse", 64'(bus.done_o), 64'd0);
        chk("u100_q_hold", bus.quotient_o, 64'd14);
        start_op(1'b1, -64'sd100, 64'd7);
        wait_done(0);
        chk_result("sm100_7", 65, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        start_op(1'b1, 64'd100, -64'sd7);
        wait_done(0);
        chk_result("s100_m7", 65, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0);
        start_op(1'b1, 64'h1234, 64'd0);
        wait_done(0);
        chk_result("dbz", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
        repeat (3) @(negedge clk);
        chk("dbz_hold", 64'(bus.div_by_zero_o), 64'd1);
        start_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(0);
        chk_result("ovf", 65, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
        start_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done(0);
        chk_result("umax_1", 65, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        start_op(1'b0, 64'd1000, 64'd10);
        repeat (9) @(negedge clk);
        bus.start_i    = 1'b1;
        bus.dividend_i = 64'd5;
        bus.divisor_i  = 64'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(10);
        chk_result("busy_ignore", 65, 64'd100, 64'd0, 1'b0);
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 64'd53;
        bus.divisor_i  = 64'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("b2b_busy", 64'(bus.busy_o), 64'd1);
        chk("b2b_q_hold", bus.quotient_o, 64'd100);
        wait_done(0);
        chk_result("b2b", 65, 64'd10, 64'd3, 1'b0);
        start_op(1'b0, 64'd999, 64'd4);
        repeat (29) @(negedge clk);
        reset_i = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_done", 64'(bus.done_o), 64'd0);
        chk("abort_q", bus.quotient_o, 64'd0);
        chk("abort_r", bus.remainder_o, 64'd0);
        @(negedge clk);
        reset_i = 1'b0;
        saw = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done_o) saw = 1'b1;
        end
        chk("abort_no_done", 64'(saw), 64'd0);
        start_op(1'b0, 64'd100, 64'd7);
        wait_done(0);
        chk_result("after_abort", 65, 64'd14, 64'd2, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
